// File: rtl/tdm_demux_1x4.sv
// 1:4 TDM demultiplexer: deserialises a 4-slot, 1-bit-per-slot frame stream
// aligned by fsync, with HUNT/LOCKED framing and error reporting.
module tdm_demux_1x4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       din,
  input  logic       fsync,
  output logic [3:0] y,
  output logic       valid,
  output logic [1:0] sel,
  output logic       locked,
  output logic       sync_err
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t     state, state_nxt;
  logic [1:0] sel_nxt;
  // Slot 3 is never buffered: it goes straight into y with slots 0..2.
  logic [2:0] shadow, shadow_nxt;
  logic [3:0] y_nxt;
  logic       valid_nxt, err_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= HUNT;
      sel      <= '0;
      shadow   <= '0;
      y        <= '0;
      valid    <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      shadow   <= shadow_nxt;
      y        <= y_nxt;
      valid    <= valid_nxt;
      sync_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    shadow_nxt = shadow;
    y_nxt      = y;
    valid_nxt  = 1'b0;
    err_nxt    = 1'b0;
    if (en) begin
      unique case (state)
        HUNT: begin
          sel_nxt = '0;
          if (fsync) begin
            shadow_nxt[0] = din;
            sel_nxt       = 2'd1;
            state_nxt     = LOCKED;
          end
        end
        LOCKED: begin
          if (fsync) begin
            // Early marker restarts the frame from slot 0; aligned marker is clean.
            err_nxt       = (sel != 2'd0);
            shadow_nxt[0] = din;
            sel_nxt       = 2'd1;
          end else if (sel == 2'd0) begin
            err_nxt   = 1'b1;
            sel_nxt   = '0;
            state_nxt = HUNT;
          end else if (sel == 2'd3) begin
            y_nxt     = {din, shadow};
            valid_nxt = 1'b1;
            sel_nxt   = '0;
          end else begin
            shadow_nxt[sel] = din;
            sel_nxt         = sel + 2'd1;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_comb begin
    locked = (state == LOCKED);
  end

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Directed bench for tdm_demux_1x4 with hand-computed expected values.
module tb_tdm_demux_1x4;

  logic       clk = 1'b0;
  logic       rst_n, en, din, fsync;
  logic [3:0] y;
  logic       valid, locked, sync_err;
  logic [1:0] sel;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  tdm_demux_1x4 dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .fsync(fsync),
    .y(y), .valid(valid), .sel(sel), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic fs, input logic d);
    en = e; fsync = fs; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] ey, input logic ev,
                         input logic [1:0] es, input logic el, input logic ee);
    check({tag, ".y"}, y, ey);
    check({tag, ".valid"}, {3'b0, valid}, {3'b0, ev});
    check({tag, ".sel"}, {2'b0, sel}, {2'b0, es});
    check({tag, ".locked"}, {3'b0, locked}, {3'b0, el});
    check({tag, ".sync_err"}, {3'b0, sync_err}, {3'b0, ee});
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; din = 1'b1; fsync = 1'b1;
    step(1, 1, 1);
    step(1, 1, 1);
    chk_all("reset", 4'b0000, 0, 2'd0, 0, 0);
    rst_n = 1'b1;

    // HUNT ignores data without a marker
    step(1, 0, 1);
    chk_all("hunt_idle", 4'b0000, 0, 2'd0, 0, 0);

    // basic frame: slots 1,0,1,1 -> y=1101
    step(1, 1, 1); chk_all("basic.s0", 4'b0000, 0, 2'd1, 1, 0);
    step(1, 0, 0); chk_all("basic.s1", 4'b0000, 0, 2'd2, 1, 0);
    step(1, 0, 1); chk_all("basic.s2", 4'b0000, 0, 2'd3, 1, 0);
    step(1, 0, 1); chk_all("basic.s3", 4'b1101, 1, 2'd0, 1, 0);

    // back-to-back 1010 then 0101, valid pulses 4 cycles apart
    step(1, 1, 0); chk_all("b2b.a0", 4'b1101, 0, 2'd1, 1, 0);
    step(1, 0, 1); chk_all("b2b.a1", 4'b1101, 0, 2'd2, 1, 0);
    step(1, 0, 0); chk_all("b2b.a2", 4'b1101, 0, 2'd3, 1, 0);
    step(1, 0, 1); chk_all("b2b.a3", 4'b1010, 1, 2'd0, 1, 0);
    step(1, 1, 1); chk_all("b2b.b0", 4'b1010, 0, 2'd1, 1, 0);
    step(1, 0, 0); chk_all("b2b.b1", 4'b1010, 0, 2'd2, 1, 0);
    step(1, 0, 1); chk_all("b2b.b2", 4'b1010, 0, 2'd3, 1, 0);
    step(1, 0, 0); chk_all("b2b.b3", 4'b0101, 1, 2'd0, 1, 0);

    // stall of 3 cycles between slots 1 and 2 of frame 0011
    step(1, 1, 1); chk_all("stall.s0", 4'b0101, 0, 2'd1, 1, 0);
    step(1, 0, 1); chk_all("stall.s1", 4'b0101, 0, 2'd2, 1, 0);
    step(0, 1, 0); chk_all("stall.h0", 4'b0101, 0, 2'd2, 1, 0);
    step(0, 0, 1); chk_all("stall.h1", 4'b0101, 0, 2'd2, 1, 0);
    step(0, 1, 1); chk_all("stall.h2", 4'b0101, 0, 2'd2, 1, 0);
    step(1, 0, 0); chk_all("stall.s2", 4'b0101, 0, 2'd3, 1, 0);
    step(1, 0, 0); chk_all("stall.s3", 4'b0011, 1, 2'd0, 1, 0);

    // early marker after slots 0,1, then 1,1,0 -> y=0111
    step(1, 1, 0); chk_all("early.s0", 4'b0011, 0, 2'd1, 1, 0);
    step(1, 0, 1); chk_all("early.s1", 4'b0011, 0, 2'd2, 1, 0);
    step(1, 1, 1); chk_all("early.mk", 4'b0011, 0, 2'd1, 1, 1);
    step(1, 0, 1); chk_all("early.r1", 4'b0011, 0, 2'd2, 1, 0);
    step(1, 0, 1); chk_all("early.r2", 4'b0011, 0, 2'd3, 1, 0);
    step(1, 0, 0); chk_all("early.r3", 4'b0111, 1, 2'd0, 1, 0);

    // early marker exactly at slot 3: no valid, y unchanged
    step(1, 1, 0); chk_all("late.s0", 4'b0111, 0, 2'd1, 1, 0);
    step(1, 0, 0); chk_all("late.s1", 4'b0111, 0, 2'd2, 1, 0);
    step(1, 0, 0); chk_all("late.s2", 4'b0111, 0, 2'd3, 1, 0);
    step(1, 1, 1); chk_all("late.mk", 4'b0111, 0, 2'd1, 1, 1);
    step(1, 0, 1); step(1, 0, 1);
    step(1, 0, 0); chk_all("late.r3", 4'b0111, 1, 2'd0, 1, 0);

    // missing marker: drop to HUNT, ignore data until fsync
    step(1, 0, 1); chk_all("miss.mk", 4'b0111, 0, 2'd0, 0, 1);
    step(1, 0, 1); chk_all("miss.i1", 4'b0111, 0, 2'd0, 0, 0);
    step(1, 0, 0); step(1, 0, 1);
    step(1, 0, 1); chk_all("miss.i4", 4'b0111, 0, 2'd0, 0, 0);

    // reset mid-frame after slot 2, then an unmarked frame is ignored
    step(1, 1, 1); chk_all("rstmid.s0", 4'b0111, 0, 2'd1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 1); chk_all("rstmid.s2", 4'b0111, 0, 2'd3, 1, 0);
    rst_n = 1'b0;
    step(1, 0, 1); chk_all("rstmid.rst", 4'b0000, 0, 2'd0, 0, 0);
    rst_n = 1'b1;
    step(1, 0, 1); step(1, 0, 1); step(1, 0, 0);
    step(1, 0, 1); chk_all("rstmid.ign", 4'b0000, 0, 2'd0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
